plab3_mem_line_mem_responder: RTL
=================================

# plab3_mem_line_mem_responder

Blocking, single-outstanding memory responder that sits on the memory side of the blocking cache's memreq/memresp interface. It accepts one line-wide request (refill read or evict write), holds it for a fixed programmable latency, and then returns exactly one response. It serves as the main-memory endpoint for cache unit and integration tests, and as a latency-configurable backing store.

## Interface

Parameters:

- `p_mem_nbytes`, 1024: storage size in bytes; must be a multiple of line bytes.
- `p_opaque_nbits`, 8: opaque field width.
- `p_addr_nbits`, 32: address width.
- `p_line_nbits`, 128: line data width; a power of two ≥ 32.
- `p_latency`, 2: extra wait cycles between request accept and response valid; 0 is legal.
- Derived: `nlines = p_mem_nbytes*8/p_line_nbits`, `obits = $clog2(p_line_nbits/8)`, `ibits = $clog2(nlines)`.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `memreq_val`  in  1  request valid.
- `memreq_rdy`  out  1  request ready.
- `memreq_type`  in  3  0=READ, 1=WRITE, 2=WRITE_INIT; other codes unsupported.
- `memreq_opaque`  in  p_opaque_nbits  tag, echoed in the response.
- `memreq_addr`  in  p_addr_nbits  byte address.
- `memreq_data`  in  p_line_nbits  write line.
- `memresp_val`  out  1  response valid.
- `memresp_rdy`  in  1  response ready.
- `memresp_type`  out  3  echo of the request type.
- `memresp_opaque`  out  p_opaque_nbits  echo of the request opaque.
- `memresp_data`  out  p_line_nbits  read line; 0 for writes and unsupported types.
- `err`  out  1  sticky; set when an unsupported type is accepted.

## Operation

- Handshake fires on a rising edge where val && rdy.
- Storage is `nlines` × `p_line_nbits`. Line index is `memreq_addr[obits +: ibits]`. Offset bits and bits above the index are ignored.
- Storage contents are not reset. Reads of never-written lines return X.
- State machine, 2-bit state, reset value IDLE:
  - IDLE: `memreq_rdy=1`, `memresp_val=0`. On accept, latch type, opaque and response data. Load the counter with `p_latency`. Go to WAIT if `p_latency>0`, otherwise go to RESP.
  - WAIT: `memreq_rdy=0`, `memresp_val=0`. Decrement the counter each cycle. When the counter is 1, the next state is RESP.
  - RESP: `memreq_rdy=0`, `memresp_val=1`. When `memresp_rdy=1`, go to IDLE.
- Accept actions, performed on the accept edge:
  - READ: the response data register gets `mem[idx]`.
  - WRITE or WRITE_INIT: `mem[idx]` gets `memreq_data`; the response data register gets 0.
  - Unsupported type: no storage write; the response data register gets 0; `err` gets 1.
- Response outputs come straight from the latched registers and stay stable while `memresp_val=1` && `!memresp_rdy`.
- No request is accepted in the same cycle a response is delivered. The earliest next accept is the cycle after the response handshake.
- Counter width is `$clog2(p_latency+1)` (minimum 1). It never wraps because it is only decremented in WAIT.

## Timing

- Reset (async, `reset=0`): state goes to IDLE immediately. `memreq_rdy=1` after reset deasserts. The following all read 0: `memresp_val`, `memresp_type`, `memresp_opaque`, `memresp_data`, `err`, and the counter.
- Reset during WAIT or RESP drops the pending response. A write that already committed on its accept edge stays in storage.
- Accept at edge t → `memresp_val` rises in the cycle after edge t+`p_latency`. Minimum request-to-response is 1 cycle when `p_latency=0`.
- Throughput is one transaction per `p_latency+2` cycles, given a response consumer that is always ready.
- Backpressure: `memresp_rdy=0` holds RESP indefinitely, with outputs frozen and `memreq_rdy=0`.
- `memreq_rdy` depends only on state, never combinationally on inputs. `memresp_val` likewise depends only on state.

## Test plan

- Reset, then WRITE addr 0x40 data 0x0123…CDEF, opaque 0x05, `p_latency=2`. Required: `memresp_val` rises in the third cycle after accept, type 1, opaque 0x05, data 0. Then READ 0x40, opaque 0x06, which returns the same line with type 0 and opaque 0x06.
- With `p_latency=0`: WRITE_INIT then READ of 0x3F0 with offset bits 0xC. Required: response 1 cycle after each accept, and the read returns the line written to index 0x3F.
- Index aliasing with `p_mem_nbytes=1024`: WRITE 0x010 data A, WRITE 0x410 data B, READ 0x010. Required: read returns B.
- Backpressure: hold `memresp_rdy=0` for 5 cycles in RESP. Required: `memresp_*` is stable, `memreq_rdy=0`, and a new request offered is not accepted until the cycle after the response handshake.
- Unsupported type 3 at 0x80, then READ 0x80. Required: the first response has type 3 and data 0, `err=1` stays set, and storage is unchanged.
- Assert `reset=0` mid-WAIT after a READ accept. Required: `memresp_val` is 0 immediately and never pulses for the dropped request, `memreq_rdy=1` after release, and a subsequent READ completes normally.

Source files
------------

// File: rtl/plab3_mem_line_mem_responder_if.sv
// Line-wide memreq/memresp channel between a blocking cache and its memory.
// The master is the cache side; the slave is the memory responder.
interface plab3_mem_line_mem_responder_if #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_line_nbits   = 128
);
  logic                      memreq_val;
  logic                      memreq_rdy;
  logic [2:0]                memreq_type;
  logic [p_opaque_nbits-1:0] memreq_opaque;
  logic [p_addr_nbits-1:0]   memreq_addr;
  logic [p_line_nbits-1:0]   memreq_data;

  logic                      memresp_val;
  logic                      memresp_rdy;
  logic [2:0]                memresp_type;
  logic [p_opaque_nbits-1:0] memresp_opaque;
  logic [p_line_nbits-1:0]   memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_data, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_type, memresp_opaque, memresp_data
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_data, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_type, memresp_opaque, memresp_data
  );
endinterface

// File: rtl/plab3_mem_line_mem_responder.sv
// Single-outstanding line memory: accepts one request, waits p_latency cycles,
// then presents one response held until consumed.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request accepted, counting down the latency
// RESP  | response valid, waiting for memresp_rdy
module plab3_mem_line_mem_responder #(
  parameter int p_mem_nbytes   = 1024,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_line_nbits   = 128,
  parameter int p_latency      = 2
) (
  input  logic clk,
  input  logic reset,
  plab3_mem_line_mem_responder_if.slave bus,
  output logic err
);
  localparam int nlines = p_mem_nbytes * 8 / p_line_nbits;
  localparam int obits  = $clog2(p_line_nbits / 8);
  localparam int ibits  = $clog2(nlines);
  localparam int cnt_w  = (p_latency > 0) ? $clog2(p_latency + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r, state_next;

  logic [cnt_w-1:0]          cnt_r;
  logic [2:0]                type_r;
  logic [p_opaque_nbits-1:0] opaque_r;
  logic [p_line_nbits-1:0]   data_r;

  logic [p_line_nbits-1:0]   store [nlines];

  logic [ibits-1:0] idx;
  logic             req_fire;
  logic             is_read;
  logic             is_write;
  logic             addr_unused;

  assign idx         = bus.memreq_addr[obits +: ibits];
  assign addr_unused = ^bus.memreq_addr;
  assign req_fire    = bus.memreq_val && bus.memreq_rdy;
  assign is_read     = (bus.memreq_type == 3'd0);
  assign is_write    = (bus.memreq_type == 3'd1) || (bus.memreq_type == 3'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next;
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: if (req_fire) state_next = (p_latency > 0) ? WAIT : RESP;
      WAIT: if (cnt_r == cnt_w'(1)) state_next = RESP;
      RESP: if (bus.memresp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.memreq_rdy  = (state_r == IDLE);
    bus.memresp_val = (state_r == RESP);
  end

  assign bus.memresp_type   = type_r;
  assign bus.memresp_opaque = opaque_r;
  assign bus.memresp_data   = data_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      type_r   <= '0;
      opaque_r <= '0;
      data_r   <= '0;
      err      <= 1'b0;
    end else if (req_fire) begin
      cnt_r    <= cnt_w'(p_latency);
      type_r   <= bus.memreq_type;
      opaque_r <= bus.memreq_opaque;
      data_r   <= is_read ? store[idx] : '0;
      if (!is_read && !is_write) err <= 1'b1;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - cnt_w'(1);
    end
  end

  // Storage is deliberately unreset; a write commits on its accept edge.
  always_ff @(posedge clk) begin
    if (reset && req_fire && is_write) store[idx] <= bus.memreq_data;
  end
endmodule
